// File: rtl/block_write_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : block_write_seq
// Description : Write-transfer sequencer for an SD host. Walks the block-write
//               datapath through single/multi-block transfers with block
//               counting, block-gap halting, auto CMD12 and busy timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module block_write_seq #(
    parameter int MaxBlockBitSize = 10,
    parameter int BlockCountWidth = 16,
    parameter int TimeoutWidth    = 24
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       sd_clk_en_p_i,
    input  logic                       start_i,
    input  logic                       multi_block_i,
    input  logic                       block_count_en_i,
    input  logic                       auto_cmd12_en_i,
    input  logic [BlockCountWidth-1:0] block_count_i,
    input  logic                       stop_at_gap_i,
    input  logic                       continue_i,
    input  logic [TimeoutWidth-1:0]    timeout_limit_i,
    input  logic                       buf_ready_i,
    output logic                       buf_release_o,
    output logic                       dw_start_o,
    input  logic                       dw_done_i,
    input  logic                       dw_crc_err_i,
    input  logic                       dw_end_bit_err_i,
    input  logic                       dw_timeout_i,
    input  logic                       dw_waiting_i,
    output logic                       auto_cmd12_req_o,
    input  logic                       auto_cmd12_done_i,
    output logic                       active_o,
    output logic                       block_gap_o,
    output logic                       xfer_complete_o,
    output logic                       crc_err_o,
    output logic                       end_bit_err_o,
    output logic                       timeout_err_o,
    output logic [BlockCountWidth-1:0] blocks_left_o
);

    if (MaxBlockBitSize < 1) begin : g_bad_block_size
        $error("MaxBlockBitSize must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_BUF = 3'd1,
        START    = 3'd2,
        XFER     = 3'd3,
        CHECK    = 3'd4,
        GAP      = 3'd5,
        CMD12    = 3'd6,
        FINISH   = 3'd7
    } state_e;

    state_e                     state_q, state_d;
    logic                       multi_q, multi_d;
    logic                       cnt_en_q, cnt_en_d;
    logic                       acmd12_en_q, acmd12_en_d;
    logic [BlockCountWidth-1:0] blocks_left_q, blocks_left_d;
    logic [TimeoutWidth-1:0]    busy_cnt_q, busy_cnt_d;
    logic                       st_crc_q, st_crc_d;
    logic                       st_end_q, st_end_d;
    logic                       st_to_q, st_to_d;
    logic                       buf_release_q, buf_release_d;
    logic                       block_gap_q, block_gap_d;
    logic                       acmd12_req_q, acmd12_req_d;
    logic                       xfer_complete_q, xfer_complete_d;
    logic                       crc_err_q, crc_err_d;
    logic                       end_bit_err_q, end_bit_err_d;
    logic                       timeout_err_q, timeout_err_d;

    always_comb begin
        state_d         = state_q;
        multi_d         = multi_q;
        cnt_en_d        = cnt_en_q;
        acmd12_en_d     = acmd12_en_q;
        blocks_left_d   = blocks_left_q;
        busy_cnt_d      = busy_cnt_q;
        st_crc_d        = st_crc_q;
        st_end_d        = st_end_q;
        st_to_d         = st_to_q;
        buf_release_d   = 1'b0;
        block_gap_d     = 1'b0;
        acmd12_req_d    = 1'b0;
        xfer_complete_d = 1'b0;
        crc_err_d       = 1'b0;
        end_bit_err_d   = 1'b0;
        timeout_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    multi_d       = multi_block_i;
                    cnt_en_d      = block_count_en_i;
                    acmd12_en_d   = auto_cmd12_en_i;
                    blocks_left_d = block_count_i;
                    if (block_count_en_i && (block_count_i == '0)) begin
                        state_d = FINISH;
                    end else begin
                        state_d = WAIT_BUF;
                    end
                end
            end
            WAIT_BUF: begin
                if (buf_ready_i) begin
                    state_d = START;
                end
            end
            START: begin
                // Leave on the strobe that the datapath samples the request on.
                if (sd_clk_en_p_i) begin
                    state_d    = XFER;
                    busy_cnt_d = '0;
                end
            end
            XFER: begin
                if (dw_done_i) begin
                    st_crc_d = dw_crc_err_i;
                    st_end_d = dw_end_bit_err_i;
                    st_to_d  = dw_timeout_i;
                    state_d  = CHECK;
                end else if (sd_clk_en_p_i && dw_waiting_i) begin
                    busy_cnt_d = busy_cnt_q + 1'b1;
                    if ((timeout_limit_i != '0) && (busy_cnt_d == timeout_limit_i)) begin
                        timeout_err_d = 1'b1;
                        state_d       = IDLE;
                    end
                end
            end
            CHECK: begin
                if (st_to_q) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else if (st_crc_q) begin
                    crc_err_d = 1'b1;
                    state_d   = IDLE;
                end else if (st_end_q) begin
                    end_bit_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    buf_release_d = 1'b1;
                    if (cnt_en_q && (blocks_left_q != '0)) begin
                        blocks_left_d = blocks_left_q - 1'b1;
                    end
                    if (!multi_q || (cnt_en_q && (blocks_left_d == '0))) begin
                        if (multi_q && acmd12_en_q) begin
                            acmd12_req_d = 1'b1;
                            state_d      = CMD12;
                        end else begin
                            state_d = FINISH;
                        end
                    end else if (stop_at_gap_i) begin
                        block_gap_d = 1'b1;
                        state_d     = GAP;
                    end else begin
                        state_d = WAIT_BUF;
                    end
                end
            end
            GAP: begin
                if (continue_i) begin
                    state_d = WAIT_BUF;
                end
            end
            CMD12: begin
                if (auto_cmd12_done_i) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                xfer_complete_d = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            multi_q         <= 1'b0;
            cnt_en_q        <= 1'b0;
            acmd12_en_q     <= 1'b0;
            blocks_left_q   <= '0;
            busy_cnt_q      <= '0;
            st_crc_q        <= 1'b0;
            st_end_q        <= 1'b0;
            st_to_q         <= 1'b0;
            buf_release_q   <= 1'b0;
            block_gap_q     <= 1'b0;
            acmd12_req_q    <= 1'b0;
            xfer_complete_q <= 1'b0;
            crc_err_q       <= 1'b0;
            end_bit_err_q   <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            multi_q         <= multi_d;
            cnt_en_q        <= cnt_en_d;
            acmd12_en_q     <= acmd12_en_d;
            blocks_left_q   <= blocks_left_d;
            busy_cnt_q      <= busy_cnt_d;
            st_crc_q        <= st_crc_d;
            st_end_q        <= st_end_d;
            st_to_q         <= st_to_d;
            buf_release_q   <= buf_release_d;
            block_gap_q     <= block_gap_d;
            acmd12_req_q    <= acmd12_req_d;
            xfer_complete_q <= xfer_complete_d;
            crc_err_q       <= crc_err_d;
            end_bit_err_q   <= end_bit_err_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    assign dw_start_o       = (state_q == START);
    assign active_o         = (state_q != IDLE);
    assign blocks_left_o    = blocks_left_q;
    assign buf_release_o    = buf_release_q;
    assign block_gap_o      = block_gap_q;
    assign auto_cmd12_req_o = acmd12_req_q;
    assign xfer_complete_o  = xfer_complete_q;
    assign crc_err_o        = crc_err_q;
    assign end_bit_err_o    = end_bit_err_q;
    assign timeout_err_o    = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_block_write_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_block_write_seq
// Description : Scoreboard bench for block_write_seq with a behavioural
//               datapath responder and an output event monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_write_seq;

    localparam int BCW = 16;
    localparam int TW  = 24;

    localparam logic [7:0] EV_START = 8'd1;
    localparam logic [7:0] EV_REL   = 8'd2;
    localparam logic [7:0] EV_GAP   = 8'd3;
    localparam logic [7:0] EV_CMD12 = 8'd4;
    localparam logic [7:0] EV_DONE  = 8'd5;
    localparam logic [7:0] EV_CRC   = 8'd6;
    localparam logic [7:0] EV_END   = 8'd7;
    localparam logic [7:0] EV_TO    = 8'd8;

    logic           clk;
    logic           rst_ni;
    logic           sd_clk_en_p_i;
    logic           start_i, multi_block_i, block_count_en_i, auto_cmd12_en_i;
    logic [BCW-1:0] block_count_i;
    logic           stop_at_gap_i, continue_i;
    logic [TW-1:0]  timeout_limit_i;
    logic           buf_ready_i, buf_release_o, dw_start_o;
    logic           dw_done_i, dw_crc_err_i, dw_end_bit_err_i, dw_timeout_i, dw_waiting_i;
    logic           auto_cmd12_req_o, auto_cmd12_done_i;
    logic           active_o, block_gap_o, xfer_complete_o;
    logic           crc_err_o, end_bit_err_o, timeout_err_o;
    logic [BCW-1:0] blocks_left_o;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [23:0] exp_q[$];
    logic [23:0] obs_q[$];
    int          resp_q[$];
    int          hang_strobes = 0;

    block_write_seq #(
        .MaxBlockBitSize(10),
        .BlockCountWidth(BCW),
        .TimeoutWidth(TW)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .sd_clk_en_p_i    (sd_clk_en_p_i),
        .start_i          (start_i),
        .multi_block_i    (multi_block_i),
        .block_count_en_i (block_count_en_i),
        .auto_cmd12_en_i  (auto_cmd12_en_i),
        .block_count_i    (block_count_i),
        .stop_at_gap_i    (stop_at_gap_i),
        .continue_i       (continue_i),
        .timeout_limit_i  (timeout_limit_i),
        .buf_ready_i      (buf_ready_i),
        .buf_release_o    (buf_release_o),
        .dw_start_o       (dw_start_o),
        .dw_done_i        (dw_done_i),
        .dw_crc_err_i     (dw_crc_err_i),
        .dw_end_bit_err_i (dw_end_bit_err_i),
        .dw_timeout_i     (dw_timeout_i),
        .dw_waiting_i     (dw_waiting_i),
        .auto_cmd12_req_o (auto_cmd12_req_o),
        .auto_cmd12_done_i(auto_cmd12_done_i),
        .active_o         (active_o),
        .block_gap_o      (block_gap_o),
        .xfer_complete_o  (xfer_complete_o),
        .crc_err_o        (crc_err_o),
        .end_bit_err_o    (end_bit_err_o),
        .timeout_err_o    (timeout_err_o),
        .blocks_left_o    (blocks_left_o)
    );

    function automatic logic [23:0] ev(input logic [7:0] t, input logic [15:0] bl);
        return {t, bl};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SD clock enable: one strobe every fourth system clock.
    initial begin
        int div;
        div = 0;
        sd_clk_en_p_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            div = div + 1;
            sd_clk_en_p_i = ((div % 4) == 0);
        end
    end

    // Datapath model: one behaviour code per block (0 ok, 1 crc, 2 end-bit,
    // 3 timeout, 4 hang in busy, 5 all error flags).
    initial begin
        int code;
        dw_done_i = 0; dw_crc_err_i = 0; dw_end_bit_err_i = 0; dw_timeout_i = 0; dw_waiting_i = 0;
        forever begin
            @(negedge clk);
            if (rst_ni && dw_start_o && sd_clk_en_p_i) begin
                code = (resp_q.size() > 0) ? resp_q.pop_front() : 0;
                dw_waiting_i = 1'b1;
                if (code == 4) begin
                    hang_strobes = 0;
                    for (int i = 0; i < 5000; i++) begin
                        @(negedge clk);
                        if (!active_o) break;
                        if (sd_clk_en_p_i) hang_strobes++;
                    end
                    dw_waiting_i = 1'b0;
                end else begin
                    repeat (3) @(negedge clk);
                    dw_waiting_i     = 1'b0;
                    dw_done_i        = 1'b1;
                    dw_crc_err_i     = (code == 1) || (code == 5);
                    dw_end_bit_err_i = (code == 2) || (code == 5);
                    dw_timeout_i     = (code == 3) || (code == 5);
                    @(negedge clk);
                    dw_done_i = 0; dw_crc_err_i = 0; dw_end_bit_err_i = 0; dw_timeout_i = 0;
                end
            end
        end
    end

    initial begin
        logic prev_start;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (dw_start_o && !prev_start) obs_q.push_back(ev(EV_START, blocks_left_o));
            prev_start = dw_start_o;
            if (buf_release_o)    obs_q.push_back(ev(EV_REL,   blocks_left_o));
            if (block_gap_o)      obs_q.push_back(ev(EV_GAP,   blocks_left_o));
            if (auto_cmd12_req_o) obs_q.push_back(ev(EV_CMD12, blocks_left_o));
            if (xfer_complete_o)  obs_q.push_back(ev(EV_DONE,  blocks_left_o));
            if (crc_err_o)        obs_q.push_back(ev(EV_CRC,   blocks_left_o));
            if (end_bit_err_o)    obs_q.push_back(ev(EV_END,   blocks_left_o));
            if (timeout_err_o)    obs_q.push_back(ev(EV_TO,    blocks_left_o));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_xfer(input bit m, input bit ce, input bit ac, input logic [BCW-1:0] cnt);
        @(negedge clk);
        multi_block_i = m; block_count_en_i = ce; auto_cmd12_en_i = ac; block_count_i = cnt;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!active_o) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [8+BCW-1:0] outs;
        rst_ni = 1'b0;
        start_i = 0; multi_block_i = 0; block_count_en_i = 0; auto_cmd12_en_i = 0;
        block_count_i = '0; stop_at_gap_i = 0; continue_i = 0; timeout_limit_i = 24'd1000;
        buf_ready_i = 1'b1; auto_cmd12_done_i = 0;
        repeat (3) @(negedge clk);
        outs = {dw_start_o, buf_release_o, auto_cmd12_req_o, active_o, block_gap_o,
                xfer_complete_o, crc_err_o, end_bit_err_o, blocks_left_o};
        n_checks++;
        if (outs !== '0 || timeout_err_o !== 1'b0)
            $display("FAIL reset_outputs: got %h/%b, required all zero", outs, timeout_err_o);
        else n_pass++;
        rst_ni = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_single();
        bit ok;
        logic [23:0] e, o;
        buf_ready_i = 1'b0;
        start_xfer(1'b0, 1'b0, 1'b0, 16'd0);
        repeat (12) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 0 || active_o !== 1'b1)
            $display("FAIL single_wait_buf: events=%0d active=%b, required 0 events active=1", obs_q.size(), active_o);
        else n_pass++;
        buf_ready_i = 1'b1;
        exp_q.push_back(ev(EV_START, 16'd0));
        exp_q.push_back(ev(EV_REL,   16'd0));
        exp_q.push_back(ev(EV_DONE,  16'd0));
        wait_idle(500, ok);
        n_checks++;
        if (!ok) $display("FAIL single_idle: still active, required idle"); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL single_event: got none, required %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL single_event: got %h, required %h", o, e); else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL single_extra: got %0d extra events, required 0", obs_q.size());
        else n_pass++;
        obs_q.delete();
    endtask

    task automatic test_multi_cmd12();
        bit ok;
        logic [23:0] e, o;
        start_xfer(1'b1, 1'b1, 1'b1, 16'd3);
        exp_q.push_back(ev(EV_START, 16'd3)); exp_q.push_back(ev(EV_REL, 16'd2));
        exp_q.push_back(ev(EV_START, 16'd2)); exp_q.push_back(ev(EV_REL, 16'd1));
        exp_q.push_back(ev(EV_START, 16'd1)); exp_q.push_back(ev(EV_REL, 16'd0));
        exp_q.push_back(ev(EV_CMD12, 16'd0));
        for (int i = 0; i < 2000 && obs_q.size() < 7; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 7 || active_o !== 1'b1)
            $display("FAIL multi_cmd12_wait: events=%0d active=%b, required 7 active=1", obs_q.size(), active_o);
        else n_pass++;
        auto_cmd12_done_i = 1'b1;
        @(negedge clk);
        auto_cmd12_done_i = 1'b0;
        exp_q.push_back(ev(EV_DONE, 16'd0));
        wait_idle(50, ok);
        n_checks++;
        if (!ok) $display("FAIL multi_idle: still active, required idle"); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL multi_event: got none, required %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL multi_event: got %h, required %h", o, e); else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL multi_extra: got %0d extra events, required 0", obs_q.size());
        else n_pass++;
        obs_q.delete();
    endtask

    task automatic test_zero_count();
        logic [23:0] e, o;
        @(negedge clk);
        multi_block_i = 1'b1; block_count_en_i = 1'b1; auto_cmd12_en_i = 1'b1; block_count_i = '0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n_checks++;
        if (xfer_complete_o !== 1'b0) $display("FAIL zero_early: got %b, required 0", xfer_complete_o); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (xfer_complete_o !== 1'b1) $display("FAIL zero_complete: got %b, required 1", xfer_complete_o); else n_pass++;
        exp_q.push_back(ev(EV_DONE, 16'd0));
        repeat (6) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL zero_event: got none, required %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL zero_event: got %h, required %h", o, e); else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != 0 || active_o !== 1'b0)
            $display("FAIL zero_extra: got %0d events active=%b, required 0/0", obs_q.size(), active_o);
        else n_pass++;
        obs_q.delete();
    endtask

    task automatic test_crc_err();
        bit ok;
        logic [23:0] e, o;
        resp_q.push_back(0);
        resp_q.push_back(1);
        start_xfer(1'b1, 1'b1, 1'b1, 16'd3);
        // A stray start mid-transfer (zero count would finish at once) must be ignored.
        repeat (2) @(negedge clk);
        block_count_i = '0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        exp_q.push_back(ev(EV_START, 16'd3)); exp_q.push_back(ev(EV_REL, 16'd2));
        exp_q.push_back(ev(EV_START, 16'd2)); exp_q.push_back(ev(EV_CRC, 16'd2));
        wait_idle(1000, ok);
        n_checks++;
        if (!ok) $display("FAIL crc_idle: still active, required idle"); else n_pass++;
        n_checks++;
        if (blocks_left_o !== 16'd2) $display("FAIL crc_blocks_left: got %0d, required 2", blocks_left_o);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL crc_event: got none, required %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL crc_event: got %h, required %h", o, e); else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL crc_extra: got %0d extra events, required 0", obs_q.size());
        else n_pass++;
        obs_q.delete();
    endtask

    task automatic test_err_priority();
        bit ok;
        logic [23:0] e, o;
        resp_q.push_back(5);
        start_xfer(1'b0, 1'b0, 1'b0, 16'd0);
        exp_q.push_back(ev(EV_START, 16'd0)); exp_q.push_back(ev(EV_TO, 16'd0));
        wait_idle(500, ok);
        resp_q.push_back(2);
        start_xfer(1'b0, 1'b0, 1'b0, 16'd0);
        exp_q.push_back(ev(EV_START, 16'd0)); exp_q.push_back(ev(EV_END, 16'd0));
        wait_idle(500, ok);
        n_checks++;
        if (!ok) $display("FAIL prio_idle: still active, required idle"); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL prio_event: got none, required %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL prio_event: got %h, required %h", o, e); else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL prio_extra: got %0d extra events, required 0", obs_q.size());
        else n_pass++;
        obs_q.delete();
    endtask

    task automatic test_timeout();
        bit ok;
        logic [23:0] e, o;
        timeout_limit_i = 24'd5;
        resp_q.push_back(4);
        start_xfer(1'b0, 1'b0, 1'b0, 16'd0);
        exp_q.push_back(ev(EV_START, 16'd0)); exp_q.push_back(ev(EV_TO, 16'd0));
        wait_idle(500, ok);
        n_checks++;
        if (!ok) $display("FAIL timeout_idle: still active, required idle"); else n_pass++;
        n_checks++;
        if (hang_strobes != 5) $display("FAIL timeout_strobes: got %0d, required 5", hang_strobes);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL timeout_event: got none, required %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL timeout_event: got %h, required %h", o, e); else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL timeout_extra: got %0d extra events, required 0", obs_q.size());
        else n_pass++;
        obs_q.delete();
        timeout_limit_i = 24'd1000;
    endtask

    task automatic test_no_timeout_reset();
        logic [8+BCW-1:0] outs;
        timeout_limit_i = '0;
        resp_q.push_back(4);
        start_xfer(1'b1, 1'b1, 1'b0, 16'd3);
        repeat (100) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 1 || active_o !== 1'b1 || blocks_left_o !== 16'd3 || dw_start_o !== 1'b0)
            $display("FAIL no_timeout: events=%0d active=%b left=%0d, required 1/1/3", obs_q.size(), active_o, blocks_left_o);
        else n_pass++;
        rst_ni = 1'b0;
        #1;
        outs = {dw_start_o, buf_release_o, auto_cmd12_req_o, active_o, block_gap_o,
                xfer_complete_o, crc_err_o, end_bit_err_o, blocks_left_o};
        n_checks++;
        if (outs !== '0 || timeout_err_o !== 1'b0)
            $display("FAIL async_reset: got %h/%b, required all zero", outs, timeout_err_o);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        obs_q.delete();
        repeat (20) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 0 || active_o !== 1'b0)
            $display("FAIL post_reset: got %0d events active=%b, required 0/0", obs_q.size(), active_o);
        else n_pass++;
        obs_q.delete();
        timeout_limit_i = 24'd1000;
    endtask

    task automatic test_gap();
        bit ok;
        logic [23:0] e, o;
        stop_at_gap_i = 1'b1;
        start_xfer(1'b1, 1'b1, 1'b0, 16'd2);
        exp_q.push_back(ev(EV_START, 16'd2)); exp_q.push_back(ev(EV_REL, 16'd1));
        exp_q.push_back(ev(EV_GAP, 16'd1));
        for (int i = 0; i < 1000 && obs_q.size() < 3; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 3 || active_o !== 1'b1)
            $display("FAIL gap_stall: events=%0d active=%b, required 3/1", obs_q.size(), active_o);
        else n_pass++;
        continue_i = 1'b1;
        @(negedge clk);
        continue_i = 1'b0;
        exp_q.push_back(ev(EV_START, 16'd1)); exp_q.push_back(ev(EV_REL, 16'd0));
        exp_q.push_back(ev(EV_DONE, 16'd0));
        wait_idle(1000, ok);
        n_checks++;
        if (!ok) $display("FAIL gap_idle: still active, required idle"); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL gap_event: got none, required %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL gap_event: got %h, required %h", o, e); else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL gap_extra: got %0d extra events, required 0", obs_q.size());
        else n_pass++;
        obs_q.delete();
        stop_at_gap_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_cmd12();
        test_zero_count();
        test_crc_err();
        test_err_priority();
        test_timeout();
        test_no_timeout_reset();
        test_gap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/block_write_seq.md
BLOCK_WRITE_SEQ -- requirements
Module: block_write_seq

Interface
REQ-001 Parameters SHALL be: MaxBlockBitSize, default 10, width of block size in bytes; BlockCountWidth, default 16, width of block counter; TimeoutWidth, default 24, width of busy-timeout counter.
REQ-002 clk_i  in  1  system clock.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 sd_clk_en_p_i  in  1  SD clock rising-edge enable; this is the datapath's update strobe.
REQ-005 start_i  in  1  one-cycle pulse: begin write transfer (write command accepted).
REQ-006 multi_block_i / block_count_en_i / auto_cmd12_en_i  in  1 each  transfer mode, sampled at start_i.
REQ-007 block_count_i  in  BlockCountWidth  number of blocks, sampled at start_i.
REQ-008 stop_at_gap_i  in  1  level: halt at the next block gap.
REQ-009 continue_i  in  1  one-cycle pulse: resume from gap.
REQ-010 timeout_limit_i  in  TimeoutWidth  busy-phase limit, in sd_clk_en_p_i ticks.
REQ-011 buf_ready_i  in  1  level: a full block is available in the write buffer.
REQ-012 buf_release_o  out  1  one-cycle pulse: current block consumed; buffer may be freed.
REQ-013 dw_start_o  out  1  level start request to the block-write datapath.
REQ-014 dw_done_i / dw_crc_err_i / dw_end_bit_err_i / dw_timeout_i  in  1 each  datapath completion pulse and status, valid with dw_done_i.
REQ-015 dw_waiting_i  in  1  datapath is in card-busy phase.
REQ-016 auto_cmd12_req_o  out  1  one-cycle pulse: issue CMD12; auto_cmd12_done_i  in  1  pulse: CMD12 finished.
REQ-017 active_o  out  1  transfer in progress; block_gap_o  out  1  pulse on entering GAP; xfer_complete_o  out  1  pulse at successful end.
REQ-018 crc_err_o / end_bit_err_o / timeout_err_o  out  1 each  one-cycle error pulses.
REQ-019 blocks_left_o  out  BlockCountWidth  remaining block count.

Function
REQ-020 FSM states SHALL be IDLE, WAIT_BUF, START, XFER, CHECK, GAP, CMD12, FINISH; all run on clk_i.
REQ-021 IDLE: on start_i, latch mode and count into blocks_left; go WAIT_BUF, except when block_count_en_i=1 and block_count_i=0, which goes FINISH with no block sent.
REQ-022 WAIT_BUF: go START when buf_ready_i=1; wait indefinitely otherwise.
REQ-023 START: assert dw_start_o; go XFER in the cycle sd_clk_en_p_i=1, so that dw_start_o is deasserted after exactly one strobe.
REQ-024 XFER: busy counter SHALL clear on entry and increment on each sd_clk_en_p_i while dw_waiting_i=1.
REQ-025 XFER busy timeout: when the counter equals timeout_limit_i, pulse timeout_err_o and go IDLE; limit 0 SHALL disable the timeout.
REQ-026 XFER: on dw_done_i, go CHECK.
REQ-027 CHECK error path: if dw_timeout_i, dw_crc_err_i or dw_end_bit_err_i is set, pulse the matching error output (priority timeout>crc>end-bit, single output) and go IDLE; no buf_release_o.
REQ-028 CHECK success path: pulse buf_release_o and decrement blocks_left if block_count_en_i latched=1 (saturate at 0).
REQ-029 CHECK last block: single-block mode, or counting enabled with blocks_left reaching 0 -> CMD12 if multi-block and auto_cmd12_en latched, else FINISH.
REQ-030 CHECK more blocks: stop_at_gap_i=1 -> GAP with block_gap_o pulse; else WAIT_BUF.
REQ-031 Multi-block with counting disabled SHALL transfer until stop_at_gap_i halts it; GAP is then terminal until continue_i.
REQ-032 GAP: on continue_i go WAIT_BUF; continue_i and stop_at_gap_i both high resumes.
REQ-033 CMD12: pulse auto_cmd12_req_o on entry; wait auto_cmd12_done_i, then FINISH.
REQ-034 FINISH: pulse xfer_complete_o, go IDLE.
REQ-035 active_o SHALL be 1 in every state except IDLE; start_i outside IDLE SHALL be ignored.
REQ-036 Pulse outputs SHALL be exactly one clk_i cycle wide.

Reset
REQ-037 On rst_ni low, the FSM SHALL go to IDLE, counters SHALL clear, and all outputs SHALL be 0 (blocks_left_o=0) asynchronously, including mid-transfer; no completion or error pulse follows reset.

Verification
REQ-038 Single block, buf_ready_i=1, clean dw_done_i -> one dw_start_o strobe, one buf_release_o, xfer_complete_o, no auto_cmd12_req_o.
REQ-039 Multi, count=3, auto CMD12 on -> three starts, blocks_left_o 3->2->1->0, auto_cmd12_req_o, then xfer_complete_o only after auto_cmd12_done_i.
REQ-040 Count enabled, block_count_i=0 -> xfer_complete_o two cycles after start_i, no dw_start_o.
REQ-041 Second of 3 blocks returns dw_crc_err_i=1 -> crc_err_o pulse, blocks_left_o=2, IDLE, no xfer_complete_o.
REQ-042 timeout_limit_i=5, dw_waiting_i held high -> timeout_err_o on the 5th strobe; limit 0 -> no timeout.
REQ-043 stop_at_gap_i=1 after block 1 of 2 -> block_gap_o, stall until continue_i, then block 2 and completion; rst_ni low in XFER -> all outputs 0 immediately.
